// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions used by the decoder, datapath and register file.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// Asynchronous register-file read port; index 0 always reads as zero.
module regfile_read_port
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = riscv_pkg::XLEN,
    parameter int unsigned ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   regs [2**ADDR_W],
    output logic [XLEN-1:0]   data
);

    // x0 is masked here so storage content at index 0 never matters.
    always_comb begin
        data = '0;
        if (addr != '0) begin
            data = regs[addr];
        end
    end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: 32 x XLEN, two async read ports, one sync write port.
module register_file
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = riscv_pkg::XLEN,
    parameter int unsigned ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [XLEN-1:0]   WD3,
    output logic [XLEN-1:0]   RD1,
    output logic [XLEN-1:0]   RD2
);

    localparam int unsigned NUM = 2 ** ADDR_W;

    logic [XLEN-1:0] regs [NUM];

    // Reset wins over a simultaneous write; writes to x0 are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (WE3 && (A3 != '0)) begin
            regs[A3] <= WD3;
        end
    end

    regfile_read_port #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) u_port1 (
        .addr (A1),
        .regs (regs),
        .data (RD1)
    );

    regfile_read_port #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) u_port2 (
        .addr (A2),
        .regs (regs),
        .data (RD2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table plus random traffic vs an array model.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic        we3;
    logic [4:0]  a1, a2, a3;
    logic [31:0] wd3;
    logic [31:0] rd1, rd2;

    int unsigned total;
    int unsigned passed;

    logic [31:0] model [32];

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pre1;
        logic [31:0] pre2;
        logic [31:0] post1;
        logic [31:0] post2;
    } vec_t;

    vec_t vecs [8];

    register_file #(
        .XLEN   (32),
        .ADDR_W (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .WE3   (we3),
        .A1    (a1),
        .A2    (a2),
        .A3    (a3),
        .WD3   (wd3),
        .RD1   (rd1),
        .RD2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    function automatic void model_commit(input logic r, input logic w, input logic [4:0] wa,
                                         input logic [31:0] d);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (w && wa != 5'd0) begin
            model[wa] = d;
        end
    endfunction

    task automatic drive(input logic r, input logic w, input logic [4:0] ra1, input logic [4:0] ra2,
                         input logic [4:0] wa, input logic [31:0] d);
        reset = r;
        we3   = w;
        a1    = ra1;
        a2    = ra2;
        a3    = wa;
        wd3   = d;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(31 - i);
            #1;
            check({tag, "_rd1"}, rd1, model_read(5'(i)));
            check({tag, "_rd2"}, rd2, model_read(5'(31 - i)));
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        // Directed table: inputs, expected before the edge, expected after the edge.
        vecs[0] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  32'd10,         32'd0,  32'd0,  32'd0,          32'd0};
        vecs[1] = '{1'b0, 1'b1, 5'd0,  5'd1,  5'd1,  32'd20,         32'd0,  32'd0,  32'd0,          32'd20};
        vecs[2] = '{1'b0, 1'b1, 5'd1,  5'd2,  5'd2,  32'd30,         32'd20, 32'd0,  32'd20,         32'd30};
        vecs[3] = '{1'b0, 1'b0, 5'd1,  5'd3,  5'd3,  32'd40,         32'd20, 32'd0,  32'd20,         32'd0};
        vecs[4] = '{1'b0, 1'b0, 5'd2,  5'd3,  5'd3,  32'd40,         32'd30, 32'd0,  32'd30,         32'd0};
        vecs[5] = '{1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 32'hDEADBEEF,   32'd0,  32'd0,  32'hDEADBEEF,   32'hDEADBEEF};
        vecs[6] = '{1'b1, 1'b1, 5'd5,  5'd1,  5'd5,  32'd55,         32'd0,  32'd20, 32'd0,          32'd0};
        vecs[7] = '{1'b0, 1'b1, 5'd5,  5'd31, 5'd5,  32'd55,         32'd0,  32'd0,  32'd55,         32'd0};

        // Initial reset, then every address must read zero on both ports.
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        @(posedge clk);
        model_commit(1'b1, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sweep("reset_sweep");

        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            drive(vecs[v].rst, vecs[v].we, vecs[v].ra1, vecs[v].ra2, vecs[v].wa, vecs[v].wd);
            #1;
            check($sformatf("vec%0d_pre_rd1", v), rd1, vecs[v].pre1);
            check($sformatf("vec%0d_pre_rd2", v), rd2, vecs[v].pre2);
            @(posedge clk);
            model_commit(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd);
            #1;
            check($sformatf("vec%0d_post_rd1", v), rd1, vecs[v].post1);
            check($sformatf("vec%0d_post_rd2", v), rd2, vecs[v].post2);
        end

        // After reset with the dropped write and one resumed write: only x5 holds data.
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        sweep("post_reset_sweep");

        // Reads follow address changes with no clock edge in between.
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd4, 5'd4, 5'd4, 32'h1234_5678);
        @(posedge clk);
        model_commit(1'b0, 1'b1, 5'd4, 32'h1234_5678);
        @(negedge clk);
        we3 = 1'b0;
        a1  = 5'd5;
        #1;
        check("comb_a1_to_x5", rd1, 32'd55);
        a1 = 5'd4;
        #1;
        check("comb_a1_to_x4", rd1, 32'h1234_5678);
        a2 = 5'd0;
        #1;
        check("comb_a2_to_x0", rd2, 32'd0);

        // Random traffic against the array model; reset asserted occasionally.
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        w;
            logic [4:0]  ra1, ra2, wa;
            logic [31:0] d;
            r   = ($urandom_range(0, 31) == 0);
            w   = $urandom_range(0, 1) != 0;
            wa  = 5'($urandom_range(0, 31));
            d   = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            @(negedge clk);
            drive(r, w, ra1, ra2, wa, d);
            #1;
            check("rand_pre_rd1", rd1, model_read(ra1));
            check("rand_pre_rd2", rd2, model_read(ra2));
            @(posedge clk);
            model_commit(r, w, wa, d);
            #1;
            check("rand_post_rd1", rd1, model_read(ra1));
            check("rand_post_rd2", rd2, model_read(ra2));
        end

        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        sweep("final_sweep");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
